mdio_gen: RTL and testbench

Management-side MDIO transaction generator: accepts a 32-bit Clause 22 frame word plus a start pulse and serialises it onto MDIO_OUT/MDIO_OE with a self-generated MDC. For read frames it releases the line after the header and captures 16 bits from MDIO_IN into RD_DATA. It sits directly upstream of the PHY-side MDIO receiver: its MDC, MDIO_OE and MDIO_OUT drive that receiver, and the receiver's MDIO_IN returns to it.

---
 rtl/mdio_pkg.sv | 36 +++
 rtl/mdio_gen_if.sv | 25 ++
 rtl/mdc_div.sv | 29 ++
 rtl/mdio_gen.sv | 147 ++++++++++++++
 tb/tb_mdio_gen.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO Clause 22 definitions: opcodes, frame field positions, lengths and FSM states.
// Used by both the management-side generator and the PHY-side receiver.
package mdio_pkg;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST_CL22  = 2'b01;

    localparam int unsigned ST_MSB     = 31;
    localparam int unsigned OP_MSB     = 29;
    localparam int unsigned OP_LSB     = 28;
    localparam int unsigned PHYADR_MSB = 27;
    localparam int unsigned PHYADR_LSB = 23;
    localparam int unsigned REGADR_MSB = 22;
    localparam int unsigned REGADR_LSB = 18;
    localparam int unsigned TA_MSB     = 17;
    localparam int unsigned TA_LSB     = 16;
    localparam int unsigned WDATA_MSB  = 15;

    localparam int unsigned HDR_LEN   = 16;
    localparam int unsigned FRAME_LEN = 32;
    localparam int unsigned RD_LEN    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSend,
        StCapt,
        StEnd
    } mdio_state_e;

    function automatic logic is_read(input logic [31:0] word);
        return word[OP_MSB:OP_LSB] == OP_READ;
    endfunction

endpackage

// File: rtl/mdio_gen_if.sv
// Bundle of the generator's host-side handshake and MDIO line signals.
// master: the generator itself; slave: the host plus the PHY-side receiver.
interface mdio_gen_if;

    logic        MDIO_START;
    logic [31:0] T_DATA;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    modport master (
        input  MDIO_START, T_DATA, MDIO_IN,
        output MDC, MDIO_OE, MDIO_OUT, RD_DATA, DATA_RDY, BUSY
    );

    modport slave (
        output MDIO_START, T_DATA, MDIO_IN,
        input  MDC, MDIO_OE, MDIO_OUT, RD_DATA, DATA_RDY, BUSY
    );

endinterface

// File: rtl/mdc_div.sv
// MDC generator: CLK/2 phase toggle with strobes marking the edge on which MDC rises or falls.
module mdc_div (
    input  logic CLK,
    input  logic rst,
    output logic mdc_o,
    output logic mdc_rise_o,
    output logic mdc_fall_o
);

    logic mdc_q, mdc_d;

    always_comb begin
        mdc_d = ~mdc_q;
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            mdc_q <= 1'b0;
        end else begin
            mdc_q <= mdc_d;
        end
    end

    // Strobes describe what the coming CLK edge does to MDC.
    assign mdc_o      = mdc_q;
    assign mdc_rise_o = ~mdc_q;
    assign mdc_fall_o = mdc_q;

endmodule

// File: rtl/mdio_gen.sv
// Management-side MDIO transaction generator: serialises a Clause 22 frame word onto
// MDIO_OUT/MDIO_OE with optional preamble and captures 16 read bits from MDIO_IN.
module mdio_gen
    import mdio_pkg::*;
#(
    parameter int unsigned PRE_LEN = 0
) (
    input logic        CLK,
    input logic        rst,
    mdio_gen_if.master bus
);

    localparam int unsigned MaxCnt = (PRE_LEN > FRAME_LEN) ? PRE_LEN : FRAME_LEN;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    logic mdc, mdc_rise, mdc_fall;

    mdc_div u_mdc_div (
        .CLK       (CLK),
        .rst       (rst),
        .mdc_o     (mdc),
        .mdc_rise_o(mdc_rise),
        .mdc_fall_o(mdc_fall)
    );

    mdio_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [31:0]      shift_q, shift_d;
    logic             read_q, read_d;
    logic [14:0]      cap_q, cap_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             data_rdy_q, data_rdy_d;
    logic             busy_q, busy_d;
    logic             oe_q, oe_d;
    logic             out_q, out_d;
    logic [CntW-1:0]  last_bit;

    assign last_bit = read_q ? CntW'(HDR_LEN - 1) : CntW'(FRAME_LEN - 1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        read_d     = read_q;
        cap_d      = cap_q;
        rd_data_d  = rd_data_q;
        data_rdy_d = 1'b0;
        busy_d     = busy_q;
        oe_d       = oe_q;
        out_d      = out_q;

        unique case (state_q)
            StIdle: begin
                if (bus.MDIO_START) begin
                    shift_d = bus.T_DATA;
                    read_d  = is_read(bus.T_DATA);
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (PRE_LEN > 0) ? StPre : StSend;
                end
            end
            StPre: begin
                if (mdc_fall) begin
                    oe_d  = 1'b1;
                    out_d = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(PRE_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                if (mdc_fall) begin
                    oe_d    = 1'b1;
                    out_d   = shift_q[31];
                    shift_d = {shift_q[30:0], 1'b0};
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == last_bit) begin
                        cnt_d   = '0;
                        state_d = read_q ? StCapt : StEnd;
                    end
                end
            end
            StCapt: begin
                // Release the line at the first fall, then sample on the following rises.
                if (mdc_fall && oe_q) begin
                    oe_d  = 1'b0;
                    out_d = 1'b0;
                end else if (mdc_rise && !oe_q) begin
                    cap_d = {cap_q[13:0], bus.MDIO_IN};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(RD_LEN - 1)) begin
                        rd_data_d  = {cap_q, bus.MDIO_IN};
                        data_rdy_d = 1'b1;
                        busy_d     = 1'b0;
                        cnt_d      = '0;
                        state_d    = StIdle;
                    end
                end
            end
            StEnd: begin
                if (mdc_fall) begin
                    oe_d    = 1'b0;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            read_q     <= 1'b0;
            cap_q      <= '0;
            rd_data_q  <= '0;
            data_rdy_q <= 1'b0;
            busy_q     <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            read_q     <= read_d;
            cap_q      <= cap_d;
            rd_data_q  <= rd_data_d;
            data_rdy_q <= data_rdy_d;
            busy_q     <= busy_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
        end
    end

    assign bus.MDC      = mdc;
    assign bus.MDIO_OE  = oe_q;
    assign bus.MDIO_OUT = out_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.DATA_RDY = data_rdy_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_mdio_gen.sv
// Scoreboard bench for mdio_gen: stimulus pushes expected line bits, OE windows and read
// results; a monitor sampling 1 time unit after each CLK edge pops and compares them.
module tb_mdio_gen;
    import mdio_pkg::*;

    typedef struct {
        int   len;
        logic busy;
    } oe_exp_t;

    typedef struct {
        logic [15:0] data;
        int          lat;
    } rd_exp_t;

    logic        CLK;
    logic        rst;
    logic        start0, start1;
    logic [31:0] tdata;
    logic        mdio_in;
    logic        sel;

    int n_cmp = 0;
    int n_bad = 0;

    logic    exp_bits[$];
    oe_exp_t exp_oe[$];
    rd_exp_t exp_rd[$];

    mdio_gen_if b0 ();
    mdio_gen_if b1 ();

    assign b0.MDIO_START = start0;
    assign b0.T_DATA     = tdata;
    assign b0.MDIO_IN    = mdio_in;
    assign b1.MDIO_START = start1;
    assign b1.T_DATA     = tdata;
    assign b1.MDIO_IN    = mdio_in;

    mdio_gen #(.PRE_LEN(0)) dut0 (
        .CLK(CLK),
        .rst(rst),
        .bus(b0)
    );

    mdio_gen #(.PRE_LEN(32)) dut1 (
        .CLK(CLK),
        .rst(rst),
        .bus(b1)
    );

    logic        m_mdc, m_oe, m_out, m_rdy, m_busy;
    logic [15:0] m_rd;

    assign m_mdc  = sel ? b1.MDC      : b0.MDC;
    assign m_oe   = sel ? b1.MDIO_OE  : b0.MDIO_OE;
    assign m_out  = sel ? b1.MDIO_OUT : b0.MDIO_OUT;
    assign m_rdy  = sel ? b1.DATA_RDY : b0.DATA_RDY;
    assign m_busy = sel ? b1.BUSY     : b0.BUSY;
    assign m_rd   = sel ? b1.RD_DATA  : b0.RD_DATA;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] make_frame(input logic [1:0] op, input logic [4:0] phy,
                                               input logic [4:0] regad, input logic [15:0] d);
        logic [31:0] w;
        w                         = '0;
        w[ST_MSB -: 2]            = ST_CL22;
        w[OP_MSB:OP_LSB]          = op;
        w[PHYADR_MSB:PHYADR_LSB]  = phy;
        w[REGADR_MSB:REGADR_LSB]  = regad;
        w[TA_MSB:TA_LSB]          = 2'b10;
        w[WDATA_MSB:0]            = d;
        return w;
    endfunction

    // Monitor / scoreboard
    logic cur_exp  = 1'b0;
    logic oe_prev  = 1'b0;
    int   oe_cnt   = 0;
    int   since_oe = 0;

    always @(posedge CLK) begin
        oe_exp_t eo;
        rd_exp_t er;
        #1;
        if (!rst) begin
            oe_prev  = 1'b0;
            oe_cnt   = 0;
            since_oe = 0;
        end else begin
            since_oe++;
            if (m_oe) begin
                oe_cnt++;
                if (!m_mdc) begin
                    if (exp_bits.size() == 0) begin
                        check("unexpected_bit", 1, 0);
                    end else begin
                        cur_exp = exp_bits.pop_front();
                        check("line_bit", {31'd0, m_out}, {31'd0, cur_exp});
                    end
                end else begin
                    check("bit_hold", {31'd0, m_out}, {31'd0, cur_exp});
                end
            end
            if (oe_prev && !m_oe) begin
                if (exp_oe.size() == 0) begin
                    check("unexpected_oe", 1, 0);
                end else begin
                    eo = exp_oe.pop_front();
                    check("oe_len", oe_cnt, eo.len);
                    check("busy_at_oe_fall", {31'd0, m_busy}, {31'd0, eo.busy});
                end
                oe_cnt   = 0;
                since_oe = 0;
            end
            if (m_rdy) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_data_rdy", 1, 0);
                end else begin
                    er = exp_rd.pop_front();
                    check("rd_data", {16'd0, m_rd}, {16'd0, er.data});
                    check("rdy_latency", since_oe, er.lat);
                    check("busy_at_rdy", {31'd0, m_busy}, 0);
                end
            end
            oe_prev = m_oe;
        end
    end

    // Stimulus helpers (all called at a negedge)
    task automatic push_write(input logic [31:0] w, input int pre, input int len);
        oe_exp_t e;
        for (int i = 0; i < pre; i++) exp_bits.push_back(1'b1);
        for (int i = 31; i >= 0; i--) exp_bits.push_back(w[i]);
        e.len  = len;
        e.busy = 1'b0;
        exp_oe.push_back(e);
    endtask

    task automatic push_read(input logic [15:0] hdr, input logic [15:0] d, input bit done);
        oe_exp_t e;
        rd_exp_t r;
        for (int i = 15; i >= 0; i--) exp_bits.push_back(hdr[i]);
        e.len  = 32;
        e.busy = 1'b1;
        exp_oe.push_back(e);
        if (done) begin
            r.data = d;
            r.lat  = 31;
            exp_rd.push_back(r);
        end
    endtask

    task automatic start_frame(input int which, input logic [31:0] w);
        tdata = w;
        if (which == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        start1 = 1'b0;
        tdata  = ~w;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("busy_timeout", {31'd0, m_busy}, 0);
    endtask

    task automatic wait_oe(input logic lvl, input int budget);
        int n = 0;
        while (m_oe !== lvl && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("oe_wait", {31'd0, m_oe}, {31'd0, lvl});
    endtask

    task automatic drive_read(input logic [15:0] v, input int nbits);
        wait_oe(1'b1, 10);
        wait_oe(1'b0, 100);
        for (int i = 15; i > 15 - nbits; i--) begin
            mdio_in = v[i];
            @(negedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic check_drained(input string tag);
        repeat (4) @(negedge CLK);
        check({tag, "_bits_left"}, exp_bits.size(), 0);
        check({tag, "_oe_left"}, exp_oe.size(), 0);
        check({tag, "_rd_left"}, exp_rd.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mdc"}, {31'd0, m_mdc}, 0);
        check({tag, "_oe"}, {31'd0, m_oe}, 0);
        check({tag, "_out"}, {31'd0, m_out}, 0);
        check({tag, "_rd"}, {16'd0, m_rd}, 0);
        check({tag, "_rdy"}, {31'd0, m_rdy}, 0);
        check({tag, "_busy"}, {31'd0, m_busy}, 0);
    endtask

    initial begin
        int lat;
        rst     = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        tdata   = '0;
        mdio_in = 1'b0;
        sel     = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        rst = 1'b1;
        repeat (3) @(negedge CLK);

        // Plain write, no preamble
        push_write(32'h5082_A5C3, 0, 64);
        start_frame(0, 32'h5082_A5C3);
        wait_idle(200);
        check_drained("write");

        // Read returning 0xC0DE
        push_read(16'h6082, 16'hC0DE, 1'b1);
        start_frame(0, make_frame(OP_READ, 5'd1, 5'd0, 16'h0000));
        drive_read(16'hC0DE, 16);
        wait_idle(100);
        check_drained("read");

        // Start while busy is ignored
        push_write(32'h5123_4567, 0, 64);
        start_frame(0, 32'h5123_4567);
        repeat (10) @(negedge CLK);
        start_frame(0, make_frame(OP_WRITE, 5'd3, 5'd4, 16'hBEEF));
        wait_idle(200);
        repeat (80) @(negedge CLK);
        check_drained("busy_start");

        // Reset after the 8th captured bit, then a clean read
        push_read(16'h6082, 16'h0000, 1'b0);
        start_frame(0, make_frame(OP_READ, 5'd1, 5'd0, 16'h0000));
        drive_read(16'hA5A5, 8);
        rst = 1'b0;
        @(negedge CLK);
        check_reset_outputs("mid_reset");
        rst = 1'b1;
        @(negedge CLK);
        push_read(16'h6082, 16'h1234, 1'b1);
        start_frame(0, make_frame(OP_READ, 5'd1, 5'd0, 16'h0000));
        drive_read(16'h1234, 16);
        wait_idle(100);
        check_drained("after_reset");

        // 32-bit preamble on the second instance
        sel = 1'b1;
        @(negedge CLK);
        push_write(32'h5000_FFFF, 32, 128);
        start_frame(1, 32'h5000_FFFF);
        wait_idle(400);
        check_drained("preamble");
        sel = 1'b0;
        @(negedge CLK);

        // Back-to-back writes: second start on the first cycle BUSY is low
        push_write(32'h5082_A5C3, 0, 64);
        start_frame(0, 32'h5082_A5C3);
        wait_idle(200);
        push_write(32'h5FFF_0001, 0, 64);
        start_frame(0, 32'h5FFF_0001);
        lat = 0;
        while (!m_oe && lat < 5) begin
            @(negedge CLK);
            lat++;
        end
        check("b2b_first_bit_latency", lat, 1);
        wait_idle(200);
        check_drained("b2b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
